fsq_arbiter: RTL and testbench

- Shares one single-precision squaring unit (handshake: x, r_i in; res, err, r_o out) among N_REQ requesters.
- Round-robin arbitration; issues the one-cycle r_i start pulse, holds x stable until r_o, returns res/err to the winner with a done pulse.
- Adds a response watchdog and a post-reset/post-timeout drain, because the squaring unit itself has no reset.
- Sits between the requesting datapath blocks and the squaring unit.

---
 rtl/fsq_arb_pkg.sv | 32 +++
 rtl/fsq_arbiter_rr_pick.sv | 25 ++
 rtl/fsq_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fsq_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsq_arb_pkg.sv
// Shared types and sizing helpers for the squaring-unit arbiter.
package fsq_arb_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  // Response payload returned to the owning requester.
  typedef struct packed {
    logic [FP_W-1:0] res;
    logic            err;
    logic            tmo;
  } rsp_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Wide enough to hold the larger of the watchdog and drain terminal counts.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fsq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module fsq_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan from the farthest offset down so the nearest request is assigned last.
  always_comb begin : pick
    int unsigned sum;
    sum   = 0;
    idx_o = '0;
    vld_o = |req_i;
    for (int unsigned i = N; i > 0; i--) begin
      sum = 32'(ptr_i) + i - 1;
      if (sum >= N) sum = sum - N;
      if (req_i[IW'(sum)]) idx_o = IW'(sum);
    end
  end

endmodule

// File: rtl/fsq_arbiter.sv
// Round-robin arbiter sharing one squaring unit, with response watchdog and
// a drain period after reset/timeout since the unit itself cannot be reset.
module fsq_arbiter
  import fsq_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [FP_W*N_REQ-1:0] x_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [FP_W-1:0]       res_o,
  output logic                  err_o,
  output logic                  tmo_o,
  output logic                  busy_o,
  output logic [FP_W-1:0]       u_x_o,
  output logic                  u_ri_o,
  input  logic [FP_W-1:0]       u_res_i,
  input  logic                  u_err_i,
  input  logic                  u_ro_i
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned CW = cnt_w(TIMEOUT, DRAIN_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  rsp_t              rsp_q, rsp_d;
  logic [FP_W-1:0]   ux_q, ux_d;
  logic              uri_q, uri_d;
  logic              busy_q, busy_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic [FP_W-1:0]   x_sel;

  fsq_arbiter_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Operand of the current winner.
  always_comb begin
    x_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_idx == IW'(k)) x_sel = x_i[k*FP_W +: FP_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rsp_d   = rsp_q;
    ux_d    = ux_q;
    uri_d   = 1'b0;

    case (state_q)
      DRAIN: begin
        if (cnt_q == DRN_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end

      IDLE: begin
        if (pick_vld) begin
          idx_d           = pick_idx;
          ux_d            = x_sel;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          uri_d           = 1'b1;
          state_d         = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      // A response arriving on the terminal count still wins over the timeout.
      WAIT: begin
        if (u_ro_i) begin
          rsp_d         = '{res: u_res_i, err: u_err_i, tmo: 1'b0};
          done_d[idx_q] = 1'b1;
          state_d       = DONE;
        end else if (cnt_q == TMO_LAST) begin
          rsp_d         = '{res: '0, err: 1'b1, tmo: 1'b1};
          done_d[idx_q] = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        ptr_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        gnt_d     = '0;
        rsp_d.tmo = 1'b0;
        if (rsp_q.tmo) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = DRAIN;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rsp_q   <= '0;
      ux_q    <= '0;
      uri_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rsp_q   <= rsp_d;
      ux_q    <= ux_d;
      uri_q   <= uri_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign res_o  = rsp_q.res;
  assign err_o  = rsp_q.err;
  assign tmo_o  = rsp_q.tmo;
  assign busy_o = busy_q;
  assign u_x_o  = ux_q;
  assign u_ri_o = uri_q;

endmodule

// File: tb/tb_fsq_arbiter.sv
// Directed bench for fsq_arbiter with a behavioural squaring-unit model.
module tb_fsq_arbiter;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int DRN = 8;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_i = '0;
  logic [32*N-1:0] x_i   = '0;
  logic [N-1:0]    gnt_o, done_o;
  logic [31:0]     res_o, u_x_o;
  logic            err_o, tmo_o, busy_o, u_ri_o;
  logic [31:0]     u_res_i = '0;
  logic            u_err_i = 1'b0;
  logic            ro_unit = 1'b0;
  logic            ro_stray = 1'b0;
  logic            u_ro_i;

  assign u_ro_i = ro_unit | ro_stray;

  fsq_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .DRAIN_CYC(DRN)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .x_i(x_i),
    .gnt_o(gnt_o), .done_o(done_o), .res_o(res_o), .err_o(err_o),
    .tmo_o(tmo_o), .busy_o(busy_o), .u_x_o(u_x_o), .u_ri_o(u_ri_o),
    .u_res_i(u_res_i), .u_err_i(u_err_i), .u_ro_i(u_ro_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ri_cnt = 0;
  int last_ri = -1;

  always @(negedge clk) if (u_ri_o) begin ri_cnt++; last_ri = cyc; end

  // Square of a normal single, truncated; {err, result}.
  function automatic logic [32:0] fsq(input logic [31:0] x);
    int e, ex;
    logic [47:0] a, p;
    logic [22:0] m;
    e = int'(x[30:23]);
    if (e == 0) return 33'd0;
    a = {24'd0, 1'b1, x[22:0]};
    p = a * a;
    ex = 2 * e - 127;
    if (p[47]) begin ex++; m = p[46:24]; end
    else m = p[45:23];
    if (ex >= 255) return {1'b1, 32'h7f800000};
    if (ex <= 0) return 33'd0;
    return {1'b0, 1'b0, ex[7:0], m};
  endfunction

  // Unit model: r_o unit_dly cycles after the start pulse (0 = never); re-reads x at the end.
  int unit_dly = 6;
  int age = 0;
  bit active = 0;
  always @(negedge clk) begin
    ro_unit = 1'b0;
    if (u_ri_o) begin active = 1; age = 0; end
    else if (active) begin
      age++;
      if (unit_dly != 0 && age == unit_dly) begin
        ro_unit = 1'b1;
        {u_err_i, u_res_i} = fsq(u_x_o);
        active = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic wait_done(output int idx, output bit ok);
    ok = 0;
    idx = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (|done_o) begin
        for (int k = 0; k < N; k++) if (done_o[k]) idx = k;
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_ri(output int c, output bit ok);
    ok = 0;
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_ri_o) begin c = cyc; ok = 1; return; end
    end
  endtask

  task automatic run_op(input int idx, input logic [31:0] x, input int dly,
                        input logic [31:0] eres, input logic eerr, input logic etmo,
                        input int elat, input string nm);
    int got, r0;
    bit ok;
    logic [N-1:0] eg;
    @(negedge clk);
    unit_dly = dly;
    x_i[idx*32 +: 32] = x;
    req_i[idx] = 1'b1;
    r0 = ri_cnt;
    wait_done(got, ok);
    if (!ok) begin bound_fail({nm, ".done"}); req_i[idx] = 1'b0; return; end
    eg = '0;
    eg[idx] = 1'b1;
    chk({nm, ".idx"}, 32'(got), 32'(idx));
    chk({nm, ".res"}, res_o, eres);
    chk({nm, ".err"}, 32'(err_o), 32'(eerr));
    chk({nm, ".tmo"}, 32'(tmo_o), 32'(etmo));
    chk({nm, ".gnt"}, 32'(gnt_o), 32'(eg));
    chk({nm, ".lat"}, 32'(cyc - last_ri), 32'(elat));
    chk({nm, ".ri_cnt"}, 32'(ri_cnt - r0), 32'd1);
    req_i[idx] = 1'b0;
  endtask

  // Release reset with requester 0 already waiting; first issue must follow the drain.
  task automatic rel_and_first(input string nm);
    int c, got, rel, r0;
    bit ok;
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    unit_dly = 6;
    x_i[31:0] = 32'h40000000;
    req_i = 4'b0001;
    r0 = ri_cnt;
    wait_ri(c, ok);
    if (!ok) bound_fail({nm, ".ri"});
    else chk({nm, ".drain_gap"}, 32'(c - rel), 32'(DRN + 1));
    wait_done(got, ok);
    if (!ok) bound_fail({nm, ".done"});
    else begin
      chk({nm, ".idx"}, 32'(got), 32'd0);
      chk({nm, ".res"}, res_o, 32'h40800000);
      chk({nm, ".err"}, 32'(err_o), 32'd0);
      chk({nm, ".tmo"}, 32'(tmo_o), 32'd0);
      chk({nm, ".ri_cnt"}, 32'(ri_cnt - r0), 32'd1);
    end
    req_i = '0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, ".gnt"}, 32'(gnt_o), 32'd0);
    chk({nm, ".done"}, 32'(done_o), 32'd0);
    chk({nm, ".res"}, res_o, 32'd0);
    chk({nm, ".err"}, 32'(err_o), 32'd0);
    chk({nm, ".tmo"}, 32'(tmo_o), 32'd0);
    chk({nm, ".u_x"}, u_x_o, 32'd0);
    chk({nm, ".u_ri"}, 32'(u_ri_o), 32'd0);
    chk({nm, ".busy"}, 32'(busy_o), 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] x;
    int          dly;
    logic [31:0] res;
    logic        err;
    logic        tmo;
    int          lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    int got, c, d, r0, nd;
    bit ok;
    logic [31:0] xr[4];
    logic [31:0] er[4];

    vt[0] = '{0, 32'h40000000,  6, 32'h40800000, 1'b0, 1'b0,  7};
    vt[1] = '{1, 32'h40400000,  6, 32'h41100000, 1'b0, 1'b0,  7};
    vt[2] = '{2, 32'h3fc00000,  6, 32'h40100000, 1'b0, 1'b0,  7};
    vt[3] = '{3, 32'h7f000000,  6, 32'h7f800000, 1'b1, 1'b0,  7};
    vt[4] = '{1, 32'hc0000000,  3, 32'h40800000, 1'b0, 1'b0,  4};
    vt[5] = '{2, 32'h40000000,  0, 32'h00000000, 1'b1, 1'b1, 16};
    vt[6] = '{0, 32'h40400000, 15, 32'h41100000, 1'b0, 1'b0, 16};
    vt[7] = '{3, 32'h40000000, 16, 32'h00000000, 1'b1, 1'b1, 16};
    vt[8] = '{0, 32'h3f800000,  2, 32'h3f800000, 1'b0, 1'b0,  3};

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("por");
    rel_and_first("first");

    for (int i = 0; i < 9; i++)
      run_op(vt[i].idx, vt[i].x, vt[i].dly, vt[i].res, vt[i].err, vt[i].tmo,
             vt[i].lat, $sformatf("vec%0d", i));

    // Reset while waiting on the unit.
    @(negedge clk);
    unit_dly = 6;
    x_i[31:0] = 32'h40400000;
    req_i = 4'b0001;
    wait_ri(c, ok);
    if (!ok) bound_fail("midrst.ri");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rel_and_first("midrst_rec");

    // Simultaneous requests 1 and 2, then 0 and 3.
    @(negedge clk);
    unit_dly = 6;
    x_i[63:32] = 32'h40400000;
    x_i[95:64] = 32'h40000000;
    req_i = 4'b0110;
    wait_done(got, ok);
    if (!ok) bound_fail("pair.a");
    else begin
      chk("pair.a.idx", 32'(got), 32'd1);
      chk("pair.a.res", res_o, 32'h41100000);
    end
    req_i[1] = 1'b0;
    wait_done(got, ok);
    if (!ok) bound_fail("pair.b");
    else begin
      chk("pair.b.idx", 32'(got), 32'd2);
      chk("pair.b.res", res_o, 32'h40800000);
    end
    req_i = '0;
    @(negedge clk);
    x_i[31:0] = 32'h3f800000;
    x_i[127:96] = 32'h40000000;
    req_i = 4'b1001;
    wait_done(got, ok);
    if (!ok) bound_fail("ptr3");
    else chk("ptr3.idx", 32'(got), 32'd3);
    req_i = '0;

    // All four held: strict rotation.
    xr = '{32'h3f800000, 32'h40400000, 32'h3fc00000, 32'h40000000};
    er = '{32'h3f800000, 32'h41100000, 32'h40100000, 32'h40800000};
    @(negedge clk);
    for (int k = 0; k < 4; k++) x_i[k*32 +: 32] = xr[k];
    req_i = 4'b1111;
    for (int n = 0; n < 12; n++) begin
      wait_done(got, ok);
      if (!ok) begin bound_fail($sformatf("rr%0d", n)); break; end
      chk($sformatf("rr%0d.idx", n), 32'(got), 32'(n % 4));
      chk($sformatf("rr%0d.res", n), res_o, er[n % 4]);
    end
    req_i = '0;

    // Stray completion while idle.
    @(negedge clk);
    @(negedge clk);
    chk("stray.busy", 32'(busy_o), 32'd0);
    r0 = ri_cnt;
    ro_stray = 1'b1;
    @(negedge clk);
    ro_stray = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (|done_o) nd++;
    end
    chk("stray.done_cnt", 32'(nd), 32'd0);
    chk("stray.ri_cnt", 32'(ri_cnt - r0), 32'd0);

    // Timeout followed by drain before the next issue.
    @(negedge clk);
    unit_dly = 0;
    x_i[95:64] = 32'h40000000;
    req_i = 4'b0100;
    wait_done(got, ok);
    if (!ok) bound_fail("tmo.done");
    else begin
      chk("tmo.idx", 32'(got), 32'd2);
      chk("tmo.tmo", 32'(tmo_o), 32'd1);
      chk("tmo.err", 32'(err_o), 32'd1);
      chk("tmo.res", res_o, 32'd0);
      chk("tmo.lat", 32'(cyc - last_ri), 32'(TMO + 1));
    end
    d = cyc;
    unit_dly = 6;
    x_i[63:32] = 32'h40400000;
    req_i = 4'b0010;
    @(negedge clk);
    chk("tmo.clear", 32'(tmo_o), 32'd0);
    chk("tmo.err_hold", 32'(err_o), 32'd1);
    chk("tmo.res_hold", res_o, 32'd0);
    wait_ri(c, ok);
    if (!ok) bound_fail("tmo.ri");
    else chk("tmo.drain_gap", 32'(c - d), 32'(DRN + 2));
    wait_done(got, ok);
    if (!ok) bound_fail("tmo.next");
    else begin
      chk("tmo.next.idx", 32'(got), 32'd1);
      chk("tmo.next.res", res_o, 32'h41100000);
      chk("tmo.next.tmo", 32'(tmo_o), 32'd0);
    end
    req_i = '0;

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
